// File: rtl/gh_proc_core.sv
// gh_proc_core: multicycle, non-pipelined 32-bit core for the Guitar Hero system.
// Each instruction runs FETCH -> EXEC, and a load adds one LOAD cycle.
// The ROM and RAM are synchronous. The register file is external and reads combinationally.
module gh_proc_core #(
   parameter logic [31:0] RESET_PC  = 32'd0,
   parameter logic [4:0]  IN_OPCODE = 5'b11111
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] address_imem,
   input  logic [31:0] q_imem,
   output logic        ctrl_writeEnable,
   output logic [4:0]  ctrl_writeReg,
   output logic [4:0]  ctrl_readRegA,
   output logic [4:0]  ctrl_readRegB,
   output logic [31:0] data_writeReg,
   input  logic [31:0] data_readRegA,
   input  logic [31:0] data_readRegB,
   output logic        wren,
   output logic [31:0] address_dmem,
   output logic [31:0] data,
   input  logic [31:0] q_dmem,
   input  logic [3:0]  buttons,
   input  logic [3:0]  intersections,
   input  logic        strum,
   input  logic        gameclk
);

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_J     = 5'b00001;
   localparam logic [4:0] OP_BNE   = 5'b00010;
   localparam logic [4:0] OP_JAL   = 5'b00011;
   localparam logic [4:0] OP_JR    = 5'b00100;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_BLT   = 5'b00110;
   localparam logic [4:0] OP_SW    = 5'b00111;
   localparam logic [4:0] OP_LW    = 5'b01000;

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_LOAD} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [4:0]  ld_rd_q, ld_rd_d;
   logic [31:0] dm_addr_q, dm_addr_d;
   logic [9:0]  gin_q;

   logic [4:0]  op, rd, rs, rt, shamt, aluop;
   logic [31:0] imm_n, tgt, pc_inc;
   logic        we;
   logic        unused_lsbs;

   assign op     = q_imem[31:27];
   assign rd     = q_imem[26:22];
   assign rs     = q_imem[21:17];
   assign rt     = q_imem[16:12];
   assign shamt  = q_imem[11:7];
   assign aluop  = q_imem[6:2];
   assign imm_n  = {{15{q_imem[16]}}, q_imem[16:0]};
   assign tgt    = {5'd0, q_imem[26:0]};
   assign pc_inc = pc_q + 32'd1;
   assign unused_lsbs = ^q_imem[1:0];

   assign address_imem     = pc_q;
   // r0 is hardwired, so the core never requests a write to it.
   assign ctrl_writeEnable = we && (ctrl_writeReg != 5'd0);

   // State, PC, pending load target and game-input sample registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         ld_rd_q   <= 5'd0;
         dm_addr_q <= 32'd0;
         gin_q     <= 10'd0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ld_rd_q   <= ld_rd_d;
         dm_addr_q <= dm_addr_d;
         gin_q     <= {gameclk, strum, intersections, buttons};
      end
   end

   // Decode, execute and next-state logic for the current cycle.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      ld_rd_d        = ld_rd_q;
      dm_addr_d      = dm_addr_q;
      ctrl_readRegA  = 5'd0;
      ctrl_readRegB  = 5'd0;
      ctrl_writeReg  = 5'd0;
      data_writeReg  = 32'd0;
      we             = 1'b0;
      wren           = 1'b0;
      address_dmem   = dm_addr_q;
      data           = 32'd0;
      case (state_q)
         S_FETCH: state_d = S_EXEC;
         S_EXEC: begin
            state_d       = S_FETCH;
            pc_d          = pc_inc;
            ctrl_readRegA = rs;
            ctrl_readRegB = rt;
            if (op == IN_OPCODE) begin
               ctrl_writeReg = rd;
               data_writeReg = {22'd0, gin_q};
               we            = 1'b1;
            end else begin
               case (op)
                  OP_RTYPE: begin
                     ctrl_writeReg = rd;
                     we            = 1'b1;
                     case (aluop)
                        5'b00000: data_writeReg = data_readRegA + data_readRegB;
                        5'b00001: data_writeReg = data_readRegA - data_readRegB;
                        5'b00010: data_writeReg = data_readRegA & data_readRegB;
                        5'b00011: data_writeReg = data_readRegA | data_readRegB;
                        5'b00100: data_writeReg = data_readRegA << shamt;
                        5'b00101: data_writeReg = 32'($signed(data_readRegA) >>> shamt);
                        default:  we = 1'b0;
                     endcase
                  end
                  OP_ADDI: begin
                     ctrl_writeReg = rd;
                     data_writeReg = data_readRegA + imm_n;
                     we            = 1'b1;
                  end
                  OP_SW: begin
                     ctrl_readRegA = rd;
                     ctrl_readRegB = rs;
                     wren          = 1'b1;
                     address_dmem  = data_readRegB + imm_n;
                     data          = data_readRegA;
                  end
                  OP_LW: begin
                     address_dmem = data_readRegA + imm_n;
                     dm_addr_d    = data_readRegA + imm_n;
                     ld_rd_d      = rd;
                     state_d      = S_LOAD;
                  end
                  OP_J: pc_d = tgt;
                  OP_JAL: begin
                     ctrl_writeReg = 5'd31;
                     data_writeReg = pc_inc;
                     we            = 1'b1;
                     pc_d          = tgt;
                  end
                  OP_JR: begin
                     ctrl_readRegA = rd;
                     pc_d          = data_readRegA;
                  end
                  OP_BNE: begin
                     ctrl_readRegA = rd;
                     ctrl_readRegB = rs;
                     if (data_readRegA != data_readRegB) pc_d = pc_inc + imm_n;
                  end
                  OP_BLT: begin
                     ctrl_readRegA = rd;
                     ctrl_readRegB = rs;
                     if ($signed(data_readRegA) < $signed(data_readRegB)) pc_d = pc_inc + imm_n;
                  end
                  default: ;
               endcase
            end
         end
         S_LOAD: begin
            state_d       = S_FETCH;
            ctrl_writeReg = ld_rd_q;
            data_writeReg = q_dmem;
            we            = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_gh_proc_core.sv
// Randomized, scoreboarded testbench for gh_proc_core.
// The bench owns the ROM, RAM and register file. An ISA-level model predicts every
// register and memory write, and a negedge monitor checks the DUT against them.
module tb_gh_proc_core;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] address_imem, q_imem;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
   logic [31:0] data_writeReg, data_readRegA, data_readRegB;
   logic        wren;
   logic [31:0] address_dmem, data, q_dmem;
   logic [3:0]  buttons = 4'd0, intersections = 4'd0;
   logic        strum = 1'b0, gameclk = 1'b0;

   gh_proc_core dut (
      .clock(clock), .reset(reset),
      .address_imem(address_imem), .q_imem(q_imem),
      .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
      .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
      .data_writeReg(data_writeReg), .data_readRegA(data_readRegA),
      .data_readRegB(data_readRegB), .wren(wren), .address_dmem(address_dmem),
      .data(data), .q_dmem(q_dmem), .buttons(buttons),
      .intersections(intersections), .strum(strum), .gameclk(gameclk)
   );

   always #5 clock = ~clock;

   logic [31:0] rom   [0:4095];
   logic [31:0] ram   [0:4095];
   logic [31:0] tb_rf [0:31];
   logic [31:0] m_rf  [0:31];
   logic [31:0] m_mem [0:4095];

   // External memories: synchronous ROM and RAM, plus a register file with combinational reads.
   always @(posedge clock) q_imem <= rom[address_imem[11:0]];
   always @(posedge clock) begin
      if (wren) ram[address_dmem[11:0]] <= data;
      q_dmem <= ram[address_dmem[11:0]];
   end
   always @(posedge clock) if (ctrl_writeEnable && ctrl_writeReg != 5'd0) tb_rf[ctrl_writeReg] <= data_writeReg;
   assign data_readRegA = (ctrl_readRegA == 5'd0) ? 32'd0 : tb_rf[ctrl_readRegA];
   assign data_readRegB = (ctrl_readRegB == 5'd0) ? 32'd0 : tb_rf[ctrl_readRegB];

   typedef struct packed {logic is_mem; logic [31:0] a; logic [31:0] d;} ev_t;
   ev_t sbq[$];
   int  n_pass = 0, n_total = 0;
   bit  mon_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Monitor: every register or RAM write the DUT makes must match the next predicted event.
   always @(negedge clock) begin
      ev_t e;
      if (mon_en) begin
         if (ctrl_writeEnable) begin
            if (sbq.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_regwrite: got r%0d=%h expected none", ctrl_writeReg, data_writeReg);
            end else begin
               e = sbq.pop_front();
               chk("ev_kind_reg", {31'd0, e.is_mem}, 32'd0);
               chk("reg_idx", {27'd0, ctrl_writeReg}, e.a);
               chk("reg_data", data_writeReg, e.d);
            end
         end
         if (wren) begin
            if (sbq.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_memwrite: got [%h]=%h expected none", address_dmem, data);
            end else begin
               e = sbq.pop_front();
               chk("ev_kind_mem", {31'd0, e.is_mem}, 32'd1);
               chk("mem_addr", address_dmem, e.a);
               chk("mem_data", data, e.d);
            end
         end
      end
   end

   function automatic logic [31:0] enc_r(input logic [4:0] al, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] sh);
      return {5'd0, rd, rs, rt, sh, al, 2'b00};
   endfunction
   function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [16:0] imm);
      return {op, rd, rs, imm};
   endfunction
   function automatic logic [31:0] enc_j(input logic [4:0] op, input logic [26:0] t);
      return {op, t};
   endfunction

   task automatic mwr(input logic [4:0] idx, input logic [31:0] v);
      if (idx != 5'd0) begin
         m_rf[idx] = v;
         sbq.push_back(ev_t'{is_mem: 1'b0, a: {27'd0, idx}, d: v});
      end
   endtask

   // ISA-level reference: interpret the program in rom until "j self".
   task automatic run_model(output logic [31:0] hpc, output bit halted);
      logic [31:0] pc, ins, n, t, a, b, v;
      logic [4:0]  op, rd, rs, rt, sh, al;
      pc = 32'd0; halted = 1'b0; hpc = 32'd0;
      for (int s = 0; s < 4000 && !halted; s++) begin
         ins = rom[pc[11:0]];
         op = ins[31:27]; rd = ins[26:22]; rs = ins[21:17]; rt = ins[16:12];
         sh = ins[11:7];  al = ins[6:2];
         n = {{15{ins[16]}}, ins[16:0]};
         t = {5'd0, ins[26:0]};
         a = m_rf[rs]; b = m_rf[rt];
         case (op)
            5'b00000: begin
               case (al)
                  5'd0: mwr(rd, a + b);
                  5'd1: mwr(rd, a - b);
                  5'd2: mwr(rd, a & b);
                  5'd3: mwr(rd, a | b);
                  5'd4: mwr(rd, a << sh);
                  5'd5: mwr(rd, $signed(a) >>> sh);
                  default: ;
               endcase
               pc = pc + 1;
            end
            5'b00101: begin mwr(rd, a + n); pc = pc + 1; end
            5'b00111: begin
               v = a + n;
               m_mem[v[11:0]] = m_rf[rd];
               sbq.push_back(ev_t'{is_mem: 1'b1, a: v, d: m_rf[rd]});
               pc = pc + 1;
            end
            5'b01000: begin v = a + n; mwr(rd, m_mem[v[11:0]]); pc = pc + 1; end
            5'b00001: if (t == pc) begin halted = 1'b1; hpc = pc; end else pc = t;
            5'b00011: begin mwr(5'd31, pc + 1); pc = t; end
            5'b00100: pc = m_rf[rd];
            5'b00010: pc = (m_rf[rd] != m_rf[rs]) ? pc + 1 + n : pc + 1;
            5'b00110: pc = ($signed(m_rf[rd]) < $signed(m_rf[rs])) ? pc + 1 + n : pc + 1;
            5'b11111: begin mwr(rd, {22'd0, gameclk, strum, intersections, buttons}); pc = pc + 1; end
            default: pc = pc + 1;
         endcase
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 4096; i++) rom[i] = 32'd0;
   endtask

   task automatic do_run(input string nm);
      logic [31:0] hpc;
      bit halted;
      int cyc;
      @(negedge clock);
      reset = 1'b0;
      mon_en = 1'b0;
      sbq.delete();
      for (int i = 0; i < 4096; i++) begin ram[i] = 32'd0; m_mem[i] = 32'd0; end
      for (int i = 0; i < 32; i++) begin tb_rf[i] = 32'd0; m_rf[i] = 32'd0; end
      repeat (2) @(negedge clock);
      run_model(hpc, halted);
      if (!halted) begin
         n_total++;
         $display("FAIL %s_model_halt: got no halt expected halt", nm);
      end
      mon_en = 1'b1;
      reset = 1'b1;
      cyc = 0;
      while (sbq.size() != 0 && cyc < 3000) begin @(negedge clock); cyc++; end
      if (sbq.size() != 0) begin
         n_total++;
         $display("FAIL %s_timeout: got %0d pending expected 0", nm, sbq.size());
      end
      repeat (6) @(negedge clock);
      chk({nm, "_halt_pc"}, address_imem, hpc);
      mon_en = 1'b0;
   endtask

   initial begin
      logic [4:0] k, r1, r2, r3;
      // Reset behaviour: abandon EXEC of addi r1,r0,5, then restart from PC 0.
      clear_rom();
      rom[0] = enc_i(5'b00101, 5'd1, 5'd0, 17'd5);
      rom[1] = enc_j(5'b00001, 27'd1);
      for (int i = 0; i < 32; i++) tb_rf[i] = 32'd0;
      repeat (3) @(negedge clock);
      chk("rst_pc", address_imem, 32'd0);
      chk("rst_we", {31'd0, ctrl_writeEnable}, 32'd0);
      chk("rst_wren", {31'd0, wren}, 32'd0);
      reset = 1'b1;
      #1 chk("fetch_we", {31'd0, ctrl_writeEnable}, 32'd0);
      @(posedge clock); #1;
      chk("exec_we", {31'd0, ctrl_writeEnable}, 32'd1);
      reset = 1'b0;
      #1;
      chk("abort_we", {31'd0, ctrl_writeEnable}, 32'd0);
      chk("abort_pc", address_imem, 32'd0);
      @(posedge clock); #1;
      chk("abort_nowrite", tb_rf[1], 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      chk("cyc2_we", {31'd0, ctrl_writeEnable}, 32'd1);
      chk("cyc2_reg", {27'd0, ctrl_writeReg}, 32'd1);
      chk("cyc2_data", data_writeReg, 32'd5);
      @(posedge clock); #1;
      chk("cyc2_written", tb_rf[1], 32'd5);

      // Directed program from the test plan.
      clear_rom();
      rom[0]  = enc_i(5'b00101, 5'd1, 5'd0, 17'd5);
      rom[1]  = enc_i(5'b00101, 5'd2, 5'd0, 17'd7);
      rom[2]  = enc_r(5'd0, 5'd3, 5'd1, 5'd2, 5'd0);
      rom[3]  = enc_r(5'd1, 5'd4, 5'd1, 5'd2, 5'd0);
      rom[4]  = enc_i(5'b00111, 5'd3, 5'd0, 17'd4);
      rom[5]  = enc_i(5'b01000, 5'd5, 5'd0, 17'd4);
      rom[6]  = enc_i(5'b00010, 5'd1, 5'd2, 17'd2);
      rom[7]  = enc_i(5'b00101, 5'd10, 5'd0, 17'd1);
      rom[8]  = enc_i(5'b00101, 5'd10, 5'd0, 17'd2);
      rom[9]  = enc_i(5'b00110, 5'd2, 5'd1, 17'd1);
      rom[10] = enc_j(5'b00011, 27'd20);
      rom[11] = enc_i(5'b11111, 5'd6, 5'd0, 17'd0);
      rom[12] = enc_i(5'b00101, 5'd0, 5'd0, 17'd9);
      rom[13] = enc_r(5'd4, 5'd7, 5'd1, 5'd0, 5'd31);
      rom[14] = enc_j(5'b00001, 27'd14);
      rom[20] = enc_i(5'b00101, 5'd8, 5'd0, 17'd3);
      rom[21] = enc_i(5'b00100, 5'd31, 5'd0, 17'd0);
      buttons = 4'b1010; intersections = 4'b0011; strum = 1'b1; gameclk = 1'b0;
      do_run("directed");
      chk("r3_add", tb_rf[3], 32'd12);
      chk("r4_sub", tb_rf[4], 32'hFFFF_FFFE);
      chk("r5_lw", tb_rf[5], 32'd12);
      chk("ram4_sw", ram[4], 32'd12);
      chk("r6_in", tb_rf[6], 32'h13A);
      chk("r7_sll31", tb_rf[7], 32'h8000_0000);
      chk("r31_jal", tb_rf[31], 32'd11);
      chk("r8_sub", tb_rf[8], 32'd3);
      chk("r10_skipped", tb_rf[10], 32'd0);

      // Random straight-line programs with forward-only branches.
      for (int p = 0; p < 8; p++) begin
         clear_rom();
         buttons = 4'($urandom); intersections = 4'($urandom);
         strum = 1'($urandom); gameclk = 1'($urandom);
         for (int i = 0; i < 16; i++) begin
            k  = 5'($urandom_range(0, 6));
            r1 = 5'($urandom_range(0, 7));
            r2 = 5'($urandom_range(0, 7));
            r3 = 5'($urandom_range(0, 7));
            case (k)
               5'd0: rom[i] = enc_i(5'b00101, r1, r2, 17'($urandom));
               5'd1: rom[i] = enc_r(5'($urandom_range(0, 5)), r1, r2, r3, 5'($urandom));
               5'd2: rom[i] = enc_i(5'b00111, r1, r2, 17'($urandom_range(0, 31)));
               5'd3: rom[i] = enc_i(5'b01000, r1, r2, 17'($urandom_range(0, 31)));
               5'd4: rom[i] = enc_i(5'b11111, r1, 5'd0, 17'd0);
               5'd5: rom[i] = enc_i(5'b00101, r1, r2, 17'($urandom_range(0, 20)));
               default: rom[i] = enc_i(($urandom_range(0, 1) != 0) ? 5'b00010 : 5'b00110,
                                       r1, r2, 17'($urandom_range(0, 2)));
            endcase
         end
         for (int i = 16; i < 20; i++) rom[i] = enc_j(5'b00001, 27'(i));
         do_run("random");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/gh_proc_core.md
Name: gh_proc_core

Overview:
- 32-bit multicycle, non-pipelined CPU core for the Guitar Hero game system.
- Fetches instructions from an external synchronous ROM and executes a compact ECE350-style ISA against an external register file and a synchronous data RAM.
- One custom instruction samples the game inputs (buttons, note intersections, strum, game clock) into a register.

Parameters:
- RESET_PC, 0, PC value loaded at reset.
- IN_OPCODE, 5'b11111, opcode of the game-input instruction.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- address_imem  out  32  instruction address; equals PC.
- q_imem  in  32  ROM data, registered; valid one cycle after address.
- ctrl_writeEnable  out  1  regfile write enable.
- ctrl_writeReg  out  5  regfile write index.
- ctrl_readRegA  out  5  regfile read port A index.
- ctrl_readRegB  out  5  regfile read port B index.
- data_writeReg  out  32  regfile write data.
- data_readRegA  in  32  combinational read data, port A.
- data_readRegB  in  32  combinational read data, port B.
- wren  out  1  RAM write enable.
- address_dmem  out  32  RAM word address; low 12 bits used.
- data  out  32  RAM write data.
- q_dmem  in  32  RAM registered read data; valid one cycle after address.
- buttons  in  4  fret buttons.
- intersections  in  4  note/target-line hit flags.
- strum  in  1  strum bar.
- gameclk  in  1  game tick.

Behaviour:
- Instruction fields: op[31:27], rd[26:22], rs[21:17], rt[16:12], shamt[11:7], aluop[6:2], N=imm[16:0] sign-extended, T=[26:0] zero-extended.
- Reset (low): PC=RESET_PC, state=FETCH, game-input register=0, all write enables 0. Takes effect immediately; an in-flight instruction is abandoned with no write.
- FETCH (1 cycle): address_imem=PC; no writes.
- EXEC (1 cycle): decodes q_imem.
  - readRegA=rs, except jr/bne/blt/sw, where readRegA=rd.
  - readRegB=rt for R-type; readRegB=rs for bne/blt/sw.
- Ops, all returning to FETCH with PC=PC+1 unless noted:
  - op 00000 R-type, by aluop: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 sll by shamt, 00101 sra by shamt. Writes rd. 32-bit wrap; no overflow trap.
  - 00101 addi: rd=rs+N.
  - 00111 sw: wren=1, address_dmem=rs+N, data=$rd.
  - 01000 lw: address_dmem=rs+N, then go to LOAD.
  - 00001 j: PC=T.
  - 00011 jal: write r31=PC+1, PC=T.
  - 00100 jr: PC=$rd.
  - 00010 bne: if $rd!=$rs, PC=PC+1+N.
  - 00110 blt: if signed $rd<$rs, PC=PC+1+N.
  - IN_OPCODE: rd={22'b0, gameclk_r, strum_r, intersections_r[3:0], buttons_r[3:0]}. The *_r values are registered every clock, so one cycle of latency.
  - Any other opcode: nop.
- LOAD (1 cycle): address held; writeReg=rd, data_writeReg=q_dmem, writeEnable=1; then FETCH.
- Timing: lw takes 3 cycles; every other instruction takes 2.
- ctrl_writeEnable is forced 0 whenever the destination is r0.
- wren is asserted only in EXEC for sw.
- PC is 32-bit; arithmetic wraps; only the low 12 bits address the ROM.
- Simultaneous lw and sw to the same address cannot occur (non-pipelined).

Test Plan:
- Reset low mid-EXEC of addi r1,r0,5 -> no write; after release, PC=0, first write occurs at cycle 2.
- addi r1,r0,5; addi r2,r0,7; add r3,r1,r2; sub r4,r1,r2 -> r3=12, r4=-2.
- sw r3,4(r0); lw r5,4(r0) -> wren pulses once with address 4 and data 12; r5=12 written in LOAD.
- bne r1,r2,+2 taken and blt r2,r1,+1 not taken -> PC jumps correctly; jal 20 writes r31=PC+1; jr r31 returns to that address.
- buttons=4'b1010, intersections=4'b0011, strum=1, gameclk=0, then IN r6 -> r6=0x13A (decimal 314).
- addi r0,r0,9 -> ctrl_writeEnable stays 0; sll by 31 of r1=5 -> 0x80000000.
